// File: rtl/cc_branch_unit.sv
// Condition-code holder and Bicc branch sequencer: stores icc from cc-modifying
// ALU ops, evaluates branch conditions on the stored icc, and runs the delay slot.
module cc_branch_unit #(
    parameter logic [3:0] CC_RST       = 4'b0000,
    parameter bit         TRAP_ON_DCTI = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       inst_valid,
    input  logic       cc_we,
    input  logic       n_in,
    input  logic       z_in,
    input  logic       c_in,
    input  logic       v_in,
    input  logic       br_valid,
    input  logic [3:0] cond,
    input  logic       annul,
    output logic       cc_n,
    output logic       cc_z,
    output logic       cc_c,
    output logic       cc_v,
    output logic       ci_out,
    output logic       take_branch,
    output logic       in_delay,
    output logic       squash,
    output logic       dcti_err
);

    typedef enum logic {IDLE, DELAY} state_t;

    state_t     state, state_nx;
    logic [3:0] icc;
    logic       eval;
    logic       take_nx, in_delay_nx, squash_nx, dcti_nx;

    // Low three bits select the base test; cond[3] complements it (BA = ~BN, ...).
    function automatic logic cond_eval(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v, base;
        n  = f[3];
        z  = f[2];
        cy = f[1];
        v  = f[0];
        case (c[2:0])
            3'd0:    base = 1'b0;
            3'd1:    base = z;
            3'd2:    base = z | (n ^ v);
            3'd3:    base = n ^ v;
            3'd4:    base = cy | z;
            3'd5:    base = cy;
            3'd6:    base = n;
            default: base = v;
        endcase
        return base ^ c[3];
    endfunction

    assign eval = cond_eval(cond, icc);

    always_comb begin
        state_nx    = state;
        take_nx     = 1'b0;
        in_delay_nx = in_delay;
        squash_nx   = squash;
        dcti_nx     = dcti_err;
        case (state)
            IDLE: begin
                if (inst_valid && br_valid) begin
                    take_nx     = eval;
                    squash_nx   = annul & (~eval | (cond == 4'b1000));
                    in_delay_nx = 1'b1;
                    state_nx    = DELAY;
                end
            end
            DELAY: begin
                // A branch sitting in the delay slot is never evaluated.
                if (inst_valid) begin
                    if (br_valid && TRAP_ON_DCTI)
                        dcti_nx = 1'b1;
                    in_delay_nx = 1'b0;
                    squash_nx   = 1'b0;
                    state_nx    = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            take_branch <= 1'b0;
            in_delay    <= 1'b0;
            squash      <= 1'b0;
            dcti_err    <= 1'b0;
        end else begin
            state       <= state_nx;
            take_branch <= take_nx;
            in_delay    <= in_delay_nx;
            squash      <= squash_nx;
            dcti_err    <= dcti_nx;
        end
    end

    // An annulled delay-slot instruction must not disturb icc.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            icc <= CC_RST;
        else if (inst_valid && cc_we && !squash)
            icc <= {n_in, z_in, c_in, v_in};
    end

    assign {cc_n, cc_z, cc_c, cc_v} = icc;
    assign ci_out                   = icc[1];

endmodule

// File: tb/tb_cc_branch_unit.sv
// Scoreboard bench for cc_branch_unit: directed instruction sequences plus
// random traffic, checked against a behavioural model of the icc/branch rules.
module tb_cc_branch_unit;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       inst_valid = 1'b0, cc_we = 1'b0;
    logic       n_in = 1'b0, z_in = 1'b0, c_in = 1'b0, v_in = 1'b0;
    logic       br_valid = 1'b0, annul = 1'b0;
    logic [3:0] cond = 4'd0;
    logic       cc_n, cc_z, cc_c, cc_v, ci_out;
    logic       take_branch, in_delay, squash, dcti_err;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct packed {
        logic [3:0] icc;
        logic       take;
        logic       dly;
        logic       sqz;
        logic       err;
    } exp_t;

    exp_t q[$];

    // Model state
    logic [3:0] m_icc;
    bit         m_dly, m_sqz, m_err;

    cc_branch_unit #(.CC_RST(4'b0000), .TRAP_ON_DCTI(1'b1)) dut (
        .clk(clk), .reset(reset), .inst_valid(inst_valid), .cc_we(cc_we),
        .n_in(n_in), .z_in(z_in), .c_in(c_in), .v_in(v_in),
        .br_valid(br_valid), .cond(cond), .annul(annul),
        .cc_n(cc_n), .cc_z(cc_z), .cc_c(cc_c), .cc_v(cc_v), .ci_out(ci_out),
        .take_branch(take_branch), .in_delay(in_delay), .squash(squash),
        .dcti_err(dcti_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Bicc truth from the architectural definitions of each mnemonic.
    function automatic bit m_eval(input logic [3:0] f, input logic [3:0] cd);
        bit n, z, c, v, r;
        n = f[3]; z = f[2]; c = f[1]; v = f[0];
        case (cd)
            4'd0:  r = 0;                  // BN
            4'd1:  r = z;                  // BE
            4'd2:  r = z || (n != v);      // BLE
            4'd3:  r = (n != v);           // BL
            4'd4:  r = c || z;             // BLEU
            4'd5:  r = c;                  // BCS
            4'd6:  r = n;                  // BNEG
            4'd7:  r = v;                  // BVS
            4'd8:  r = 1;                  // BA
            4'd9:  r = !z;                 // BNE
            4'd10: r = !(z || (n != v));   // BG
            4'd11: r = (n == v);           // BGE
            4'd12: r = !(c || z);          // BGU
            4'd13: r = !c;                 // BCC
            4'd14: r = !n;                 // BPOS
            default: r = !v;               // BVC
        endcase
        return r;
    endfunction

    // Drive one cycle of inputs and push the model's post-edge expectation.
    task automatic cyc(input bit iv, input bit we, input logic [3:0] f,
                       input bit br, input logic [3:0] cd, input bit an);
        exp_t e;
        bit   t;
        @(negedge clk);
        inst_valid = iv; cc_we = we; {n_in, z_in, c_in, v_in} = f;
        br_valid = br; cond = cd; annul = an;
        t = 0;
        if (!m_dly) begin
            if (iv && br) begin
                t     = m_eval(m_icc, cd);
                m_sqz = an && (!t || cd == 4'b1000);
                m_dly = 1;
            end
            if (iv && we) m_icc = f;
        end else begin
            if (iv && we && !m_sqz) m_icc = f;
            if (iv) begin
                if (br) m_err = 1;
                m_dly = 0;
                m_sqz = 0;
            end
        end
        e.icc = m_icc; e.take = t; e.dly = m_dly; e.sqz = m_sqz; e.err = m_err;
        q.push_back(e);
    endtask

    task automatic idle_inputs();
        inst_valid = 0; cc_we = 0; br_valid = 0; annul = 0; cond = 0;
        {n_in, z_in, c_in, v_in} = 4'b0000;
    endtask

    task automatic model_reset();
        m_icc = 4'b0000; m_dly = 0; m_sqz = 0; m_err = 0;
    endtask

    task automatic chk_reset_outputs(input string nm);
        chk({nm, "_icc"}, {cc_n, cc_z, cc_c, cc_v}, 4'b0000);
        chk({nm, "_ctl"}, {take_branch, in_delay, squash, dcti_err}, 4'b0000);
        chk({nm, "_ci"}, {3'b0, ci_out}, 4'b0000);
    endtask

    // Monitor: one expected snapshot per driven cycle, sampled after the edge.
    always begin
        @(posedge clk);
        #1;
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("icc", {cc_n, cc_z, cc_c, cc_v}, e.icc);
            chk("ci_out", {3'b0, ci_out}, {3'b0, e.icc[1]});
            chk("take_branch", {3'b0, take_branch}, {3'b0, e.take});
            chk("in_delay", {3'b0, in_delay}, {3'b0, e.dly});
            chk("squash", {3'b0, squash}, {3'b0, e.sqz});
            chk("dcti_err", {3'b0, dcti_err}, {3'b0, e.err});
        end
    end

    task automatic drain();
        int budget;
        budget = 20;
        while (q.size() > 0 && budget > 0) begin
            @(posedge clk);
            budget--;
        end
        @(posedge clk);
        #2;
        n_chk++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain_timeout: %0d entries left, expected 0", q.size());
        end
    endtask

    initial begin
        model_reset();
        idle_inputs();
        #3;
        chk_reset_outputs("por");
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 0;

        // subcc 8-7 -> 0000, BG taken, delay slot writes icc
        cyc(1, 1, 4'b0000, 0, 4'd0, 0);
        cyc(1, 0, 4'b0000, 1, 4'b1010, 0);
        cyc(1, 1, 4'b1000, 0, 4'd0, 0);
        // cmp 5-5 -> Z, BNE annulled, squashed slot keeps icc 0100
        cyc(1, 1, 4'b0100, 0, 4'd0, 0);
        cyc(1, 0, 4'b0000, 1, 4'b1001, 1);
        cyc(1, 1, 4'b1111, 0, 4'd0, 0);
        // BA annulled, slot stalls 3 cycles (ignored cc write), then retires
        cyc(1, 0, 4'b0000, 1, 4'b1000, 1);
        repeat (3) cyc(0, 1, 4'b1111, 0, 4'd0, 0);
        cyc(1, 1, 4'b1011, 0, 4'd0, 0);
        // BN not annulled
        cyc(1, 0, 4'b0000, 1, 4'b0000, 0);
        cyc(1, 0, 4'b0000, 0, 4'd0, 0);
        // addcc C=1 then addx
        cyc(1, 1, 4'b0010, 0, 4'd0, 0);
        cyc(1, 1, 4'b0000, 0, 4'd0, 0);
        // branch with simultaneous cc write: BE sees old Z=0
        cyc(1, 1, 4'b0100, 1, 4'b0001, 0);
        cyc(1, 0, 4'b0000, 0, 4'd0, 0);
        // branch in delay slot: no second pulse, sticky dcti_err
        cyc(1, 0, 4'b0000, 1, 4'b1000, 0);
        cyc(1, 0, 4'b0000, 1, 4'b1000, 0);
        cyc(1, 0, 4'b0000, 0, 4'd0, 0);
        cyc(1, 1, 4'b0001, 0, 4'd0, 0);
        // enter DELAY with squash=1, then reset asynchronously mid-cycle
        cyc(1, 1, 4'b1110, 0, 4'd0, 0);
        cyc(1, 0, 4'b0000, 1, 4'b1000, 1);
        @(negedge clk);
        idle_inputs();
        drain();
        #2;
        reset = 1;
        #1;
        chk_reset_outputs("async_reset");
        model_reset();
        @(posedge clk);
        @(negedge clk);
        reset = 0;

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            cyc($urandom_range(3, 0) != 0, $urandom_range(1, 0),
                4'($urandom_range(15, 0)), $urandom_range(3, 0) == 0,
                4'($urandom_range(15, 0)), $urandom_range(1, 0));
        end
        @(negedge clk);
        idle_inputs();
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/cc_branch_unit.md
Name: cc_branch_unit

Overview:
- Consumer end of the ALU condition-code interface.
- Holds the integer condition codes (icc: N, Z, C, V) written by the ALU's cc-modifying ops (op[4]=1) and feeds the registered carry back to the ALU as Ci for addx/subx.
- Evaluates SPARC-style Bicc conditions against the stored icc.
- Sequences the one-instruction delay slot, including annul (squash) handling.

Parameters:
- CC_RST, 4'b0000: reset value of {N,Z,C,V}.
- TRAP_ON_DCTI, 1: 1 sets sticky dcti_err when a branch arrives in a delay slot; 0 ignores it silently.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- inst_valid  in  1  instruction-advance strobe; one instruction retires per cycle it is high
- cc_we  in  1  current instruction modifies icc (ALU op[4])
- n_in, z_in, c_in, v_in  in  1 each  ALU flag outputs for the current instruction
- br_valid  in  1  current instruction is a Bicc
- cond  in  4  Bicc condition field
- annul  in  1  Bicc annul bit
- cc_n, cc_z, cc_c, cc_v  out  1 each  registered icc
- ci_out  out  1  equals cc_c; drives the ALU Ci
- take_branch  out  1  one-cycle registered pulse: branch taken
- in_delay  out  1  high while awaiting the delay-slot instruction
- squash  out  1  high during in_delay when the delay-slot instruction is annulled
- dcti_err  out  1  sticky error flag

Behaviour:
- Reset (async, any state, including mid-delay-slot):
  - {cc_n,cc_z,cc_c,cc_v} = CC_RST.
  - take_branch, in_delay, squash, dcti_err = 0.
  - FSM = IDLE.
- icc write: at the clock edge, if inst_valid & cc_we & ~squash, then icc <= {n_in,z_in,c_in,v_in}. Otherwise icc holds.
  - A squashed instruction never writes icc.
  - Writes with inst_valid=0 are ignored.
- Condition evaluation is combinational on the registered icc, never on the *_in inputs. A same-cycle cc write is therefore not seen by the branch in that cycle.
  - 0 BN: 0
  - 1 BE: Z
  - 2 BLE: Z|(N^V)
  - 3 BL: N^V
  - 4 BLEU: C|Z
  - 5 BCS: C
  - 6 BNEG: N
  - 7 BVS: V
  - 8 BA: 1
  - 9..15: complement of cond-8 (BNE, BG, BGE, BGU, BCC, BPOS, BVC)
- FSM states: IDLE, DELAY.
  - IDLE, on inst_valid & br_valid:
    - take_branch <= eval (one-cycle pulse).
    - squash <= annul & (~eval | cond==4'b1000).
    - FSM -> DELAY, in_delay <= 1.
  - IDLE otherwise: take_branch <= 0.
  - DELAY:
    - take_branch <= 0 after its single pulse.
    - Waits any number of cycles with inst_valid=0; squash and in_delay hold.
    - On inst_valid: the delay-slot instruction retires (squashed if squash=1), then FSM -> IDLE and in_delay, squash <= 0.
    - If br_valid is also high in that cycle: the branch is not evaluated (no take_branch); dcti_err <= 1 when TRAP_ON_DCTI.
- Latency:
  - Branch decision appears 1 cycle after its inst_valid.
  - icc visible 1 cycle after the writing instruction.
  - Back-to-back: a cc write in cycle t is seen by a branch in cycle t+1.
- Simultaneous br_valid & cc_we in IDLE: icc updates at the edge; the branch evaluates the old icc.
- dcti_err clears only on reset.

Test Plan:
- reset mid-DELAY with squash=1: all outputs 0 immediately (no clock edge); icc=0000.
- subcc 8-7 writes icc NZCV=0000, then BG (cond 1010), annul=0: take_branch=1 one cycle later, squash=0; the next instruction with cc_we writes icc.
- cmp 5-5 gives Z=1, then BNE (1001), annul=1: take_branch=0, squash=1; the delay-slot instruction with cc_we=1 and flags 1111 leaves icc at 0100.
- BA (1000) with annul=1: take_branch=1, squash=1. BN (0000) with annul=0: take_branch=0, squash=0, in_delay=1.
- Addcc producing C=1, then addx: ci_out=1 on the next cycle. Branch and cc_we in the same cycle with old Z=0, new Z=1, BE: not taken, cc_z=1 afterwards.
- Branch in the delay slot: no second take_branch, dcti_err=1 and sticky. In DELAY with inst_valid=0 for 3 cycles: in_delay and squash hold.
